// File: rtl/datapath_input_packer.sv
// Packs 16- or 32-bit CPU bus writes into 32-bit longwords for a FIFO.
// Tracks an accepted-halfword count and sticky error and overrun flags.
module datapath_input_packer (
  input  logic        CLK45,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic        LATCH,
  input  logic        WIDE,
  input  logic        FLUSH,
  input  logic        ID_ACK,
  input  logic        CLR_ERR,
  output logic [31:0] ID,
  output logic        ID_VALID,
  output logic        RDY,
  output logic        PADDED,
  output logic        ERR,
  output logic        OVR,
  output logic [7:0]  HCNT
);

  typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_id, w_id_d;
  logic        r_padded, w_padded_d;
  logic        r_err, w_err_d;
  logic        r_ovr, w_ovr_d;
  logic [7:0]  r_hcnt, w_hcnt_d;
  logic        w_rdy, w_take, w_in_half, w_drain;

  assign w_rdy     = (r_state != StFull) | ID_ACK;
  assign w_take    = LATCH & w_rdy;
  assign w_in_half = (r_state == StHalf);
  assign w_drain   = (r_state == StFull) & ID_ACK;

  // A LATCH accepted in FULL only happens alongside ID_ACK, so it behaves as from EMPTY.
  always_comb begin
    w_state_d  = r_state;
    w_id_d     = r_id;
    w_padded_d = r_padded;
    w_err_d    = r_err;
    w_ovr_d    = r_ovr;
    w_hcnt_d   = r_hcnt;

    if (CLR_ERR) begin
      w_err_d = 1'b0;
      w_ovr_d = 1'b0;
    end
    if (LATCH && !w_rdy) begin
      w_ovr_d = 1'b1;
    end

    if (w_take) begin
      w_padded_d = 1'b0;
      w_state_d  = StFull;
      if (WIDE) begin
        w_id_d   = DATA;
        w_hcnt_d = r_hcnt + 8'd2;
        if (w_in_half) begin
          w_err_d = 1'b1;
        end
      end else begin
        w_hcnt_d = r_hcnt + 8'd1;
        if (w_in_half) begin
          w_id_d[15:0] = DATA[31:16];
        end else begin
          w_id_d[31:16] = DATA[31:16];
          w_state_d     = StHalf;
        end
      end
    end else if (FLUSH && w_in_half) begin
      w_id_d[15:0] = 16'h0000;
      w_padded_d   = 1'b1;
      w_state_d    = StFull;
    end else if (w_drain) begin
      w_state_d  = StEmpty;
      w_padded_d = 1'b0;
    end
  end

  always_ff @(posedge CLK45 or posedge RST) begin
    if (RST) begin
      r_state  <= StEmpty;
      r_id     <= 32'h0000_0000;
      r_padded <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_hcnt   <= 8'h00;
    end else begin
      r_state  <= w_state_d;
      r_id     <= w_id_d;
      r_padded <= w_padded_d;
      r_err    <= w_err_d;
      r_ovr    <= w_ovr_d;
      r_hcnt   <= w_hcnt_d;
    end
  end

  assign ID       = r_id;
  assign ID_VALID = (r_state == StFull);
  assign RDY      = w_rdy;
  assign PADDED   = r_padded;
  assign ERR      = r_err;
  assign OVR      = r_ovr;
  assign HCNT     = r_hcnt;

endmodule

// File: tb/tb_datapath_input_packer.sv
// Directed bench for datapath_input_packer: per-cycle model comparison plus literal checks.
module tb_datapath_input_packer;

  logic        CLK45 = 1'b0;
  logic        RST;
  logic [31:0] DATA;
  logic        LATCH, WIDE, FLUSH, ID_ACK, CLR_ERR;
  logic [31:0] ID;
  logic        ID_VALID, RDY, PADDED, ERR, OVR;
  logic [7:0]  HCNT;

  int n_tests = 0;
  int n_fail  = 0;

  datapath_input_packer dut (
    .CLK45   (CLK45),
    .RST     (RST),
    .DATA    (DATA),
    .LATCH   (LATCH),
    .WIDE    (WIDE),
    .FLUSH   (FLUSH),
    .ID_ACK  (ID_ACK),
    .CLR_ERR (CLR_ERR),
    .ID      (ID),
    .ID_VALID(ID_VALID),
    .RDY     (RDY),
    .PADDED  (PADDED),
    .ERR     (ERR),
    .OVR     (OVR),
    .HCNT    (HCNT)
  );

  always #5 CLK45 = ~CLK45;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of halfwords held (0, 1 or 2) plus the assembled word and flags.
  int          m_held = 0;
  logic [31:0] m_id   = 32'h0;
  logic        m_pad  = 1'b0;
  logic        m_err  = 1'b0;
  logic        m_ovr  = 1'b0;
  int          m_cnt  = 0;

  always @(posedge CLK45 or posedge RST) begin
    int held;
    bit full, rdy;
    if (RST) begin
      m_held = 0; m_id = 32'h0; m_pad = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_cnt = 0;
    end else begin
      full = (m_held == 2);
      rdy  = !full || ID_ACK;
      held = (full && ID_ACK) ? 0 : m_held;
      if (CLR_ERR) begin m_err = 1'b0; m_ovr = 1'b0; end
      if (LATCH && !rdy) begin
        m_ovr = 1'b1;
      end else if (LATCH) begin
        m_pad = 1'b0;
        if (WIDE) begin
          if (held == 1) m_err = 1'b1;
          m_id = DATA; m_held = 2; m_cnt = (m_cnt + 2) % 256;
        end else if (held == 1) begin
          m_id[15:0] = DATA[31:16]; m_held = 2; m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_id[31:16] = DATA[31:16]; m_held = 1; m_cnt = (m_cnt + 1) % 256;
        end
      end else if (FLUSH && held == 1) begin
        m_id[15:0] = 16'h0; m_pad = 1'b1; m_held = 2;
      end else if (full && ID_ACK) begin
        m_held = 0; m_pad = 1'b0;
      end
    end
  end

  always @(negedge CLK45) begin
    chk("m_id",    ID,        m_id);
    chk("m_valid", {31'b0, ID_VALID}, {31'b0, m_held == 2});
    chk("m_rdy",   {31'b0, RDY},      {31'b0, (m_held != 2) || ID_ACK});
    chk("m_pad",   {31'b0, PADDED},   {31'b0, m_pad});
    chk("m_err",   {31'b0, ERR},      {31'b0, m_err});
    chk("m_ovr",   {31'b0, OVR},      {31'b0, m_ovr});
    chk("m_hcnt",  {24'b0, HCNT},     m_cnt[31:0]);
  end

  // Drive one cycle of inputs, pass one rising edge, return 1 time unit after it with inputs idle.
  task automatic step(input bit l, input bit w, input logic [31:0] d,
                      input bit f, input bit a, input bit c);
    LATCH = l; WIDE = w; DATA = d; FLUSH = f; ID_ACK = a; CLR_ERR = c;
    @(posedge CLK45);
    #1;
    LATCH = 0; WIDE = 0; DATA = 32'h0; FLUSH = 0; ID_ACK = 0; CLR_ERR = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_id",    ID,                32'h0);
    chk("rst_valid", {31'b0, ID_VALID}, 32'h0);
    chk("rst_rdy",   {31'b0, RDY},      32'h1);
    chk("rst_hcnt",  {24'b0, HCNT},     32'h0);
    @(posedge CLK45);
    #1;
    RST = 1'b0;
  endtask

  typedef struct { bit l; bit w; logic [31:0] d; bit f; bit a; bit c; } vec_t;
  vec_t vecs[12] = '{
    '{1, 0, 32'h1234_0000, 0, 0, 0}, '{0, 0, 32'h0,         0, 1, 0},
    '{1, 0, 32'h5678_0000, 1, 1, 0}, '{1, 1, 32'h9ABC_DEF0, 0, 1, 0},
    '{0, 0, 32'h0,         1, 0, 0}, '{1, 0, 32'h0F0F_0000, 0, 0, 1},
    '{0, 0, 32'h0,         0, 1, 0}, '{0, 0, 32'h0,         1, 0, 0},
    '{1, 0, 32'h7777_0000, 0, 0, 0}, '{0, 0, 32'h0,         1, 0, 0},
    '{1, 0, 32'h8888_0000, 0, 1, 0}, '{0, 0, 32'h0,         0, 1, 1}
  };

  initial begin
    RST = 1'b1; LATCH = 0; WIDE = 0; DATA = 32'h0; FLUSH = 0; ID_ACK = 0; CLR_ERR = 0;
    repeat (2) @(posedge CLK45);
    #1;
    RST = 1'b0;

    // Wide write from EMPTY, honoured on first edge after reset.
    step(1, 1, 32'h1234_5678, 0, 0, 0);
    chk("wide_id",    ID,                32'h1234_5678);
    chk("wide_valid", {31'b0, ID_VALID}, 32'h1);
    chk("wide_hcnt",  {24'b0, HCNT},     32'h2);
    chk("wide_rdy",   {31'b0, RDY},      32'h0);
    step(0, 0, 32'h0, 0, 1, 0);
    chk("ack_valid",  {31'b0, ID_VALID}, 32'h0);
    chk("ack_hold",   ID,                32'h1234_5678);

    // Two halfwords.
    do_reset();
    step(1, 0, 32'hAAAA_0000, 0, 0, 0);
    chk("half1_valid", {31'b0, ID_VALID}, 32'h0);
    step(1, 0, 32'hBBBB_0000, 0, 0, 0);
    chk("half2_id",    ID,                32'hAAAA_BBBB);
    chk("half2_valid", {31'b0, ID_VALID}, 32'h1);
    chk("half2_hcnt",  {24'b0, HCNT},     32'h2);

    // Flush padding.
    do_reset();
    step(1, 0, 32'hCAFE_0000, 0, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0);
    chk("flush_id",   ID,              32'hCAFE_0000);
    chk("flush_pad",  {31'b0, PADDED}, 32'h1);
    chk("flush_hcnt", {24'b0, HCNT},   32'h1);
    step(0, 0, 32'h0, 0, 1, 0);
    chk("flush_ack_valid", {31'b0, ID_VALID}, 32'h0);
    chk("flush_ack_pad",   {31'b0, PADDED},   32'h0);

    // Refill on ack, then overrun with coincident clear.
    step(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    step(1, 1, 32'h1111_2222, 0, 1, 0);
    chk("refill_valid", {31'b0, ID_VALID}, 32'h1);
    chk("refill_id",    ID,                32'h1111_2222);
    step(1, 1, 32'h3333_4444, 0, 0, 0);
    chk("ovr_set", {31'b0, OVR}, 32'h1);
    chk("ovr_id",  ID,           32'h1111_2222);
    step(0, 0, 32'h0, 0, 0, 1);
    chk("ovr_clr", {31'b0, OVR}, 32'h0);
    step(1, 0, 32'h5555_0000, 0, 0, 1);
    chk("ovr_set_wins", {31'b0, OVR}, 32'h1);

    // LATCH beats FLUSH in HALF.
    do_reset();
    step(1, 0, 32'h5555_0000, 0, 0, 0);
    step(1, 0, 32'h6666_0000, 1, 0, 0);
    chk("prio_id",  ID,              32'h5555_6666);
    chk("prio_pad", {31'b0, PADDED}, 32'h0);

    // HCNT wrap and ERR on wide-in-half.
    do_reset();
    for (int i = 0; i < 255; i++) step(1, 0, {i[15:0], 16'h0}, 0, 1, 0);
    chk("cnt_ff", {24'b0, HCNT}, 32'hFF);
    step(1, 1, 32'h0BAD_F00D, 0, 0, 0);
    chk("cnt_wrap", {24'b0, HCNT}, 32'h01);
    chk("err_set",  {31'b0, ERR},  32'h1);
    chk("err_id",   ID,            32'h0BAD_F00D);
    step(0, 0, 32'h0, 0, 0, 1);
    chk("err_clr",  {31'b0, ERR},  32'h0);

    // Reset while in HALF, then a halfword lands high.
    do_reset();
    step(1, 0, 32'h4321_0000, 0, 0, 0);
    do_reset();
    chk("rst_half_valid", {31'b0, ID_VALID}, 32'h0);
    step(1, 0, 32'hBEEF_0000, 0, 0, 0);
    chk("post_rst_id",    ID,                32'hBEEF_0000);
    chk("post_rst_valid", {31'b0, ID_VALID}, 32'h0);

    // Mixed table, model-checked only.
    foreach (vecs[i]) step(vecs[i].l, vecs[i].w, vecs[i].d, vecs[i].f, vecs[i].a, vecs[i].c);
    step(0, 0, 32'h0, 0, 0, 0);

    @(negedge CLK45);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
